prach_tdm_sched: RTL and testbench
==================================

Name: prach_tdm_sched

Overview:
- Time-division slot scheduler for the 8-channel PRACH DDC chain.
- Generates the per-cycle channel index, data-valid and sync pulse that sequence the mixer input.
- Generates the per-stage decimated valid strobes the half-band cascade (hb1..hb5) uses to gate coefficient phase and output.
- Aligns the whole slot/round pattern to an external frame sync and reports misaligned resyncs.

Parameters:
- NUM_CHN, 8, number of TDM channel slots per round (2..256).
- NUM_STAGES, 5, number of decimate-by-2 stages; width of round counter and stage_dv.

Ports:
- clk  input  1  datapath clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  level; scheduler runs only while high.
- sync_in  input  1  single-cycle frame sync pulse.
- chn_mask  input  NUM_CHN  per-slot enable; bit i low suppresses dv for channel i.
- sch_dv  output  1  slot valid (mixer din_dv).
- sch_chn  output  8  current slot channel index (mixer din_chn).
- sch_sync  output  1  one-cycle pulse on first slot after alignment.
- stage_dv  output  NUM_STAGES  bit k: hb(k+1) output-valid strobe for the current slot.
- round_cnt  output  NUM_STAGES  current round number, wraps.
- running  output  1  high in RUN state.
- sync_err  output  1  one-cycle pulse on misaligned resync.

Behaviour:
- Reset values: all outputs 0; state IDLE; slot counter 0; round counter 0.
- All outputs are registered.
- States:
  - IDLE: outputs 0. enable=1 -> ARMED.
  - ARMED: outputs 0, waits for sync. sync_in=1 -> RUN. enable=0 -> IDLE.
  - RUN: enable=0 -> IDLE. sync_in=1 -> stays in RUN, with counters realigned.
- Sync latency: sync_in sampled high at edge T gives, at edge T+1: sch_sync=1, sch_chn=0, round_cnt=0.
- Slot counter (RUN): increments by 1 per cycle and wraps NUM_CHN-1 -> 0. Round counter increments on that wrap, modulo 2^NUM_STAGES.
- Outputs in RUN:
  - sch_chn = slot counter.
  - sch_dv = chn_mask[slot].
  - stage_dv[k] = sch_dv AND (round_cnt[k:0] all ones). So stage k fires once every 2^(k+1) rounds, on the last round of its decimation period.
- chn_mask is sampled every cycle without shadowing. A change affects the next registered slot only.
- Resync in RUN: sync_in at edge T forces slot=0, round=0 and sch_sync=1 at T+1.
  - sync_err pulses at T+1 unless the slot that would have followed was already slot 0 of round 0 (aligned resync).
  - An aligned resync still pulses sch_sync.
- sync_in together with enable=0: the enable drop wins. Next state IDLE, no sch_sync, no sync_err.
- sync_in in IDLE is ignored. ARMED needs a fresh sync_in after entry.
- enable drop mid-round: all outputs 0 on the next edge and counters reset. A subsequent re-enable must resync.
- Asynchronous reset mid-operation: everything clears immediately. No outputs until enable is high and a sync is seen.
- sch_sync coincides with a slot-0 output and carries that slot's dv.
- NUM_CHN=1 is illegal. Enforce with an elaboration-time check.

Test Plan:
- Reset/arm:
  - Stimulus: rst_n low 5 cycles, then enable=1, no sync for 20 cycles.
  - Required: all outputs 0 and running=0 throughout. Sync at cycle 30 gives sch_sync=1, sch_chn=0, running=1 at cycle 31.
- Round-robin and mask:
  - Stimulus: mask=8'b1011_0111, run 16 cycles after sync.
  - Required: sch_chn sequence 0..7, 0..7. sch_dv low exactly at chn 3 and 6. round_cnt is 0 then 1.
- Decimation strobes:
  - Stimulus: mask=all ones, run 32 rounds.
  - Required: stage_dv[0] high in rounds 1,3,5,...; stage_dv[4] high only in round 31, on all 8 slots.
  - Required: round_cnt wraps 31 -> 0 without sch_sync.
- Aligned vs misaligned resync:
  - Stimulus: sync_in exactly at the last slot (chn 7) of round 31.
  - Required: sch_sync=1, sync_err=0.
  - Stimulus: sync_in at chn 4 of round 2.
  - Required next cycle: sch_chn=0, round_cnt=0, sch_sync=1, sync_err=1.
- Enable drop:
  - Stimulus: enable=0 at chn 5, same cycle as sync_in.
  - Required next cycle: all outputs 0, no sync_err.
  - Stimulus: re-enable.
  - Required: outputs stay 0 until the next sync.
- Async reset mid-run:
  - Stimulus: rst_n pulsed low between clock edges at chn 2.
  - Required: outputs 0 immediately, before the next edge. After release with enable=1, the scheduler waits in ARMED.

Source files
------------

// File: rtl/prach_tdm_sched_if.sv
// Slot-schedule bus from the PRACH TDM scheduler to the mixer and half-band cascade.
interface prach_tdm_sched_if #(
    parameter int unsigned NUM_STAGES = 5
);
    logic                  sch_dv;
    logic [7:0]            sch_chn;
    logic                  sch_sync;
    logic [NUM_STAGES-1:0] stage_dv;
    logic [NUM_STAGES-1:0] round_cnt;

    modport master (
        output sch_dv,
        output sch_chn,
        output sch_sync,
        output stage_dv,
        output round_cnt
    );

    modport slave (
        input sch_dv,
        input sch_chn,
        input sch_sync,
        input stage_dv,
        input round_cnt
    );
endinterface

// File: rtl/prach_tdm_sched.sv
// TDM slot/round scheduler for the 8-channel PRACH DDC chain, aligned to an external frame sync.
// Drives per-slot channel index, data valid, sync pulse and per-stage decimated valid strobes.
module prach_tdm_sched #(
    parameter int unsigned NUM_CHN    = 8,
    parameter int unsigned NUM_STAGES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sync_in,
    input  logic [NUM_CHN-1:0]  chn_mask,
    prach_tdm_sched_if.master   sch,
    output logic                running,
    output logic                sync_err
);

    localparam int unsigned CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_CHN - 1);

    if (NUM_CHN < 2 || NUM_CHN > 256) begin : g_bad_num_chn
        $error("prach_tdm_sched: NUM_CHN must be in 2..256");
    end
    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("prach_tdm_sched: NUM_STAGES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         slot_q, slot_d, slot_inc;
    logic [NUM_STAGES-1:0] round_q, round_d, round_inc;
    logic [NUM_STAGES-1:0] stage_q, stage_d, ones_pfx;
    logic                  dv_q, dv_d;
    logic                  sync_q, sync_d;
    logic                  err_q, err_d;
    logic                  run_q, run_d;
    logic                  wrap;

    // Free-running successor of the current slot/round, used for both advance and alignment check
    always_comb begin
        wrap      = (slot_q == LAST_SLOT);
        slot_inc  = wrap ? '0 : slot_q + CW'(1);
        round_inc = wrap ? round_q + NUM_STAGES'(1) : round_q;
    end

    always_comb begin
        state_d = state_q;
        slot_d  = '0;
        round_d = '0;
        sync_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sync_in) begin
                    state_d = RUN;
                    sync_d  = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sync_in) begin
                    // Resync is aligned only if the free-running pattern was about to restart anyway
                    sync_d = 1'b1;
                    err_d  = (slot_inc != '0) || (round_inc != '0);
                end else begin
                    slot_d  = slot_inc;
                    round_d = round_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        run_d = (state_d == RUN);
        dv_d  = run_d & chn_mask[slot_d];

        // Stage k fires on the last round of each 2^(k+1)-round decimation period
        ones_pfx    = '0;
        ones_pfx[0] = round_d[0];
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            ones_pfx[k] = ones_pfx[k-1] & round_d[k];
        end
        stage_d = {NUM_STAGES{dv_d}} & ones_pfx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            round_q <= '0;
            stage_q <= '0;
            dv_q    <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            round_q <= round_d;
            stage_q <= stage_d;
            dv_q    <= dv_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    assign sch.sch_dv    = dv_q;
    assign sch.sch_chn   = 8'(slot_q);
    assign sch.sch_sync  = sync_q;
    assign sch.stage_dv  = stage_q;
    assign sch.round_cnt = round_q;
    assign running       = run_q;
    assign sync_err      = err_q;

endmodule

// File: tb/tb_prach_tdm_sched.sv
// Directed-vector bench for prach_tdm_sched: arm, round-robin/mask, decimation strobes, resync, enable drop, async reset.
module tb_prach_tdm_sched;

    localparam int unsigned NUM_CHN    = 8;
    localparam int unsigned NUM_STAGES = 5;
    localparam logic [7:0]  MASK_PAT   = 8'b1011_0111;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               sync_in;
    logic [NUM_CHN-1:0] chn_mask;
    logic               running;
    logic               sync_err;

    int n_vec;
    int n_err;

    prach_tdm_sched_if #(.NUM_STAGES(NUM_STAGES)) sch_bus ();

    prach_tdm_sched #(
        .NUM_CHN    (NUM_CHN),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .sync_in  (sync_in),
        .chn_mask (chn_mask),
        .sch      (sch_bus.master),
        .running  (running),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {running, sync_err, sch_sync, sch_dv, stage_dv[4:0], round_cnt[4:0], sch_chn[7:0]}
    function automatic logic [21:0] outs();
        return {running, sync_err, sch_bus.sch_sync, sch_bus.sch_dv,
                sch_bus.stage_dv, sch_bus.round_cnt, sch_bus.sch_chn};
    endfunction

    function automatic logic [21:0] exp_run(input logic sync, input logic err, input logic dv,
                                            input int round, input int chn);
        logic [4:0] stg;
        for (int k = 0; k < 5; k++) begin
            stg[k] = dv && (((round + 1) % (1 << (k + 1))) == 0);
        end
        return {1'b1, err, sync, dv, stg, 5'(round), 8'(chn)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        sync_in  = 1'b0;
        chn_mask = MASK_PAT;

        repeat (5) tick();
        check("reset_outs", 32'(outs()), 32'h0);

        // Sync while IDLE is ignored
        rst_n   = 1'b1;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("idle_sync_ignored", 32'(outs()), 32'h0);

        // Armed without sync for 20 cycles
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("armed_quiet", 32'(outs()), 32'h0);
        end

        // Sync -> slot 0 round 0 with sch_sync, then 32 full rounds
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("first_sync", 32'(outs()), 32'(exp_run(1'b1, 1'b0, MASK_PAT[0], 0, 0)));
        for (int c = 1; c < 256; c++) begin
            logic [7:0] m;
            m        = (c < 16) ? MASK_PAT : 8'hFF;
            chn_mask = m;
            tick();
            check("slot_seq", 32'(outs()), 32'(exp_run(1'b0, 1'b0, m[c % 8], c / 8, c % 8)));
        end
        tick();
        check("round_wrap_no_sync", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 0, 0)));

        // Advance to chn 7 of round 31, then aligned resync
        repeat (255) tick();
        check("pre_aligned_pos", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 31, 7)));
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("aligned_resync", 32'(outs()), 32'(exp_run(1'b1, 1'b0, 1'b1, 0, 0)));

        // Misaligned resync at chn 4 of round 2
        repeat (20) tick();
        check("pre_misalign_pos", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 2, 4)));
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("misaligned_resync", 32'(outs()), 32'(exp_run(1'b1, 1'b1, 1'b1, 0, 0)));
        tick();
        check("err_single_pulse", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 0, 1)));

        // Enable drop at chn 5 together with sync: drop wins
        repeat (4) tick();
        check("pre_drop_pos", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 0, 5)));
        enable  = 1'b0;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("enable_drop", 32'(outs()), 32'h0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reenable_quiet", 32'(outs()), 32'h0);
        end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("reenable_sync", 32'(outs()), 32'(exp_run(1'b1, 1'b0, 1'b1, 0, 0)));

        // Async reset between edges at chn 2
        repeat (2) tick();
        check("pre_reset_pos", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 0, 2)));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 32'(outs()), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_armed", 32'(outs()), 32'h0);
        end
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("post_reset_sync", 32'(outs()), 32'(exp_run(1'b1, 1'b0, 1'b1, 0, 0)));
        tick();
        check("post_reset_slot1", 32'(outs()), 32'(exp_run(1'b0, 1'b0, 1'b1, 0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
